// File: rtl/fifo_rd_packer.sv
// Read-side packer for a first-word-fall-through FIFO: gathers RATIO narrow
// words LSB-lane first into one wide word on a valid/ready port; flush emits a partial word.
module fifo_rd_packer #(
  parameter  int WIDTH = 8,
  parameter  int RATIO = 4,
  localparam int CW    = $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [CW-1:0]          out_count,
  output logic                   out_last
);

  logic [RATIO-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]               acc_cnt_q, acc_cnt_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        out_valid_q, out_valid_d;
  logic [WIDTH*RATIO-1:0]      out_data_q, out_data_d;
  logic [CW-1:0]               out_count_q, out_count_d;
  logic                        out_last_q, out_last_d;

  logic          full, take, xfer, pop;
  logic [CW-1:0] lane_sel;

  always_comb begin
    full       = (acc_cnt_q == CW'(RATIO));
    take       = !out_valid_q || out_ready;
    xfer       = take && (full || (flush_pend_q && acc_cnt_q != '0));
    pop        = !rst && !fifo_empty && !flush_pend_q && (!full || xfer);
    fifo_rd_en = pop;
    // A pop that coincides with a transfer starts the next word at lane 0
    lane_sel   = xfer ? '0 : acc_cnt_q;

    acc_d = acc_q;
    for (int i = 0; i < RATIO; i++)
      if (pop && lane_sel == CW'(i)) acc_d[i] = fifo_rd_data;

    acc_cnt_d = acc_cnt_q;
    if (pop)       acc_cnt_d = xfer ? CW'(1) : acc_cnt_q + CW'(1);
    else if (xfer) acc_cnt_d = '0;

    // A pending flush retires on its transfer, or at once if nothing is held;
    // further flush pulses while pending are absorbed.
    flush_pend_d = flush_pend_q;
    if (flush_pend_q) begin
      if (xfer || acc_cnt_q == '0) flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_count_d = acc_cnt_q;
      out_last_d  = flush_pend_q;
      for (int i = 0; i < RATIO; i++)
        out_data_d[i*WIDTH +: WIDTH] = (CW'(i) < acc_cnt_q) ? acc_q[i] : '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
    end
  end

  // Lane storage needs no reset: stale lanes are masked by the count
  always_ff @(posedge clk) acc_q <= acc_d;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FWFT FIFO model on the input, scoreboard of
// expected packed words built as words are queued, compared on each output handshake.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int CW    = $clog2(RATIO) + 1;

  logic                   clk = 1'b0;
  logic                   rst, fifo_empty, fifo_rd_en, flush;
  logic [WIDTH-1:0]       fifo_rd_data;
  logic                   out_valid, out_ready, out_last;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [CW-1:0]          out_count;

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH*RATIO-1:0] d;
    int                     cnt;
    logic                   last;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH*RATIO-1:0] m_acc;
  int               m_n;
  logic             gate, do_pop;
  int               checks, errors;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void refresh();
    fifo_empty   = gate || fq.size() == 0;
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  function automatic void push_word(input logic [WIDTH-1:0] w);
    exp_t e;
    fq.push_back(w);
    m_acc[m_n*WIDTH +: WIDTH] = w;
    m_n++;
    if (m_n == RATIO) begin
      e.d = m_acc; e.cnt = RATIO; e.last = 1'b0;
      sb.push_back(e);
      m_n = 0; m_acc = '0;
    end
    refresh();
  endfunction

  // Advance one cycle; the FIFO head moves only after a pop seen before the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (do_pop && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (fq.size() != 0 && n < 2000) begin cyc(); n++; end
    chk(tag, 64'(fq.size()), 0);
    repeat (3) cyc();
  endtask

  task automatic wait_sb(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin cyc(); n++; end
    chk(tag, 64'(sb.size()), 0);
  endtask

  // Output monitor: pop/compare on handshake, hold-stable under backpressure
  logic                   stall_prev = 1'b0;
  logic [WIDTH*RATIO+CW:0] held;
  always @(negedge clk) begin
    exp_t e;
    do_pop = fifo_rd_en;
    if (fifo_empty) chk("pop_while_empty", 64'(fifo_rd_en), 0);
    if (!rst) begin
      if (stall_prev) chk("hold_stable", 64'({out_valid, out_data, out_count, out_last}),
                          64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 64'(out_data), 64'hdead);
        else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_count", 64'(out_count), 64'(e.cnt));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_data, out_count, out_last};
    end else stall_prev = 1'b0;
  end

  initial begin
    exp_t e;
    checks = 0; errors = 0; m_n = 0; m_acc = '0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; gate = 1'b0; do_pop = 1'b0;
    refresh();
    repeat (2) cyc();

    // Reset state, pop suppressed while in reset
    push_word(8'h01);
    @(negedge clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 0);
    chk("rst_outs", 64'({out_valid, out_data, out_count, out_last}), 0);
    cyc();
    rst = 1'b0;

    // 1: eight words stream back-to-back
    for (int i = 2; i <= 8; i++) push_word(8'(i));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_rd_en_run", 64'(fifo_rd_en), 1);
      cyc();
    end
    @(negedge clk);
    chk("t1_rd_en_done", 64'(fifo_rd_en), 0);
    wait_sb("t1_outputs", 50);

    // 2: partial word via flush
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    wait_drain("t2_drain");
    e.d = m_acc; e.cnt = m_n; e.last = 1'b1;
    sb.push_back(e); m_n = 0; m_acc = '0;
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_sb("t2_flush_out", 50);

    // 3: backpressure with twelve words queued
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'h30 + 8'(i));
    repeat (20) cyc();
    @(negedge clk);
    chk("t3_valid", 64'(out_valid), 1);
    chk("t3_held_data", 64'(out_data), 64'h33323130);
    chk("t3_rd_en", 64'(fifo_rd_en), 0);
    chk("t3_fifo_left", 64'(fq.size()), 4);
    cyc();
    out_ready = 1'b1;
    wait_sb("t3_drain_out", 100);

    // 4: flush with nothing held: no word, pops stall for one cycle only
    repeat (3) cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    push_word(8'h55);
    @(negedge clk);
    chk("t4_stall", 64'(fifo_rd_en), 0);
    chk("t4_no_valid", 64'(out_valid), 0);
    cyc();
    @(negedge clk);
    chk("t4_resume", 64'(fifo_rd_en), 1);
    chk("t4_no_valid2", 64'(out_valid), 0);

    // 5: reset with two lanes filled discards the partial word
    push_word(8'h66);
    wait_drain("t5_drain");
    rst = 1'b1; cyc(); rst = 1'b0;
    m_n = 0; m_acc = '0;
    @(negedge clk);
    chk("t5_outs_zero", 64'({out_valid, out_data, out_count, out_last}), 0);
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    wait_sb("t5_repack", 50);

    // 6: random empty/ready toggling over 1000 words
    for (int i = 0; i < 1000; i++) push_word(8'($urandom));
    begin
      int n = 0;
      while ((sb.size() != 0 || fq.size() != 0) && n < 20000) begin
        gate      = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        refresh();
        cyc();
        n++;
      end
    end
    gate = 1'b0; out_ready = 1'b1; refresh();
    wait_sb("t6_stream", 200);
    chk("t6_fifo_empty", 64'(fq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
